// File: rtl/cc_pkg.sv
// ---------------------------------------------------------------------------
// cc_pkg
// Shared definitions for the shared-encoder arbiter:
//   DEF_DATA_WIDTH / DEF_CODE_WIDTH : default data and codeword widths
//   PAD_PATTERN                     : fixed low nibble appended to every word
//   state_t                         : arbiter FSM states (IDLE, HOLD)
// ---------------------------------------------------------------------------
package cc_pkg;

    localparam int         DEF_DATA_WIDTH = 8;
    localparam int         DEF_CODE_WIDTH = DEF_DATA_WIDTH + 4;
    localparam logic [3:0] PAD_PATTERN    = 4'b1010;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : cc_pkg

// File: rtl/direct_encoder.sv
// ---------------------------------------------------------------------------
// direct_encoder
// Purely combinational encoder: codeword = {data, PAD_PATTERN}.
// Ports:
//   data     : input  DATA_WIDTH  raw data word
//   codeword : output CODE_WIDTH  data in the upper bits, pad nibble in [3:0]
// ---------------------------------------------------------------------------
module direct_encoder
    import cc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CODE_WIDTH = DEF_CODE_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [CODE_WIDTH-1:0] codeword
);

    assign codeword = {data, PAD_PATTERN};

endmodule : direct_encoder

// File: rtl/enc_share_arbiter.sv
// ---------------------------------------------------------------------------
// enc_share_arbiter
// Round-robin arbiter letting NUM_REQ requesters share one encoder. The
// winner's data is encoded and registered, so a word granted in cycle t is
// presented with out_valid in cycle t+1 and held until out_ready.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : 1 = new grants allowed (a held word drains regardless)
//   req_valid    : per-requester valid
//   req_data     : requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    : one-hot accept, only in the grant cycle
//   out_valid    : codeword valid (state == HOLD)
//   out_ready    : downstream accept
//   out_codeword : registered encoded word
//   out_id       : index of the requester that owns out_codeword
//   busy         : state != IDLE
// ---------------------------------------------------------------------------
module enc_share_arbiter
    import cc_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CODE_WIDTH = DEF_CODE_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CODE_WIDTH-1:0]         out_codeword,
    output logic [$clog2(NUM_REQ)-1:0]    out_id,
    output logic                          busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t              state, state_next;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     ptr_next;
    logic                found;
    logic                grant;
    logic [DATA_WIDTH-1:0] win_data;
    logic [CODE_WIDTH-1:0] win_code;

    // First valid requester at or above ptr, wrapping. Scanning from the
    // farthest offset down lets the nearest one overwrite the result last.
    // Result is {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [ID_W-1:0]    ptr);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx_v;
        int              idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_v = ID_W'(idx);
            if (valid[idx_v]) res = {1'b1, idx_v};
        end
        return res;
    endfunction

    assign {found, winner} = rr_pick(req_valid, rr_ptr);

    // rst_n gates the grant so req_ready is forced low during reset.
    assign grant = rst_n && enable && found && ((state == IDLE) || out_ready);

    assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    direct_encoder #(
        .DATA_WIDTH (DATA_WIDTH),
        .CODE_WIDTH (CODE_WIDTH)
    ) u_encoder (
        .data     (win_data),
        .codeword (win_code)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state: a grant always (re)fills HOLD; otherwise HOLD drains on out_ready
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant) state_next = HOLD;
            HOLD: begin
                if (grant)          state_next = HOLD;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        out_valid = (state == HOLD);
        busy      = (state == HOLD);
    end

    // Output word, owner id and round-robin pointer change only on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_codeword <= '0;
            out_id       <= '0;
            rr_ptr       <= '0;
        end else if (grant) begin
            out_codeword <= win_code;
            out_id       <= winner;
            rr_ptr       <= ptr_next;
        end
    end

endmodule : enc_share_arbiter

// File: tb/tb_enc_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_enc_share_arbiter
// Directed test of enc_share_arbiter with hand-computed expected values.
// Inputs change 1 ns after the rising edge; outputs are sampled after that.
// ---------------------------------------------------------------------------
module tb_enc_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_codeword;
    logic [1:0]  out_id;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    enc_share_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .CODE_WIDTH (12)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword),
        .out_id       (out_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [11:0] cw, input logic [1:0] id);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".busy"},  {31'd0, busy},      {31'd0, v});
        check({tag, ".code"},  {20'd0, out_codeword}, {20'd0, cw});
        check({tag, ".id"},    {30'd0, out_id},    {30'd0, id});
    endtask

    initial begin
        // Reset with every requester asking: nothing may be accepted.
        rst_n     = 1'b0;
        enable    = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h1234_5678;
        out_ready = 1'b1;
        #12;
        check("rst.ready", {28'd0, req_ready}, 32'h0);
        check_out("rst", 1'b0, 12'h000, 2'd0);
        req_valid = 4'b0000;
        #5 rst_n = 1'b1;              // released between edges
        step();
        check_out("idle", 1'b0, 12'h000, 2'd0);

        // Requester 2 sends AA.
        req_valid = 4'b0100;
        req_data  = 32'h00AA_0000;
        #1 check("r2.ready", {28'd0, req_ready}, 32'h4);
        step();
        req_valid = 4'b0000;
        #1 check_out("r2", 1'b1, 12'hAAA, 2'd2);
        check("r2.ready_after", {28'd0, req_ready}, 32'h0);
        step();
        check_out("r2.drain", 1'b0, 12'hAAA, 2'd2);

        // Wrap-around: rr_ptr is 3; requester 3 then requester 0.
        req_valid = 4'b1000;
        req_data  = 32'h5500_0000;
        #1 check("wrap3.ready", {28'd0, req_ready}, 32'h8);
        step();
        check_out("wrap3", 1'b1, 12'h55A, 2'd3);
        req_valid = 4'b0001;
        req_data  = 32'h0000_0011;
        #1 check("wrap0.ready", {28'd0, req_ready}, 32'h1);
        step();
        check_out("wrap0", 1'b1, 12'h11A, 2'd0);
        req_valid = 4'b0000;
        step();
        check_out("wrap.drain", 1'b0, 12'h11A, 2'd0);

        // Reset mid-HOLD: rr_ptr is 1, requester 1 sends FF and is stalled.
        req_valid = 4'b0010;
        req_data  = 32'h0000_FF00;
        out_ready = 1'b0;
        step();
        req_valid = 4'b0000;
        check_out("pre_rst", 1'b1, 12'hFFA, 2'd1);
        #2 rst_n = 1'b0;
        #1 check_out("mid_rst", 1'b0, 12'h000, 2'd0);
        #3 rst_n = 1'b1;
        step();
        check_out("post_rst", 1'b0, 12'h000, 2'd0);

        // All four valid continuously: grants 0,1,2,3,0 back to back.
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 check($sformatf("rr%0d.ready", k), {28'd0, req_ready}, 32'd1 << (k % 4));
            step();
            check_out($sformatf("rr%0d", k), 1'b1, {4'h1, 2'b00, 2'(k % 4), 4'hA}, 2'(k % 4));
        end
        req_valid = 4'b0000;
        step();
        check_out("rr.drain", 1'b0, 12'h10A, 2'd0);

        // Requester 1 sends 3C, downstream stalls for 5 cycles.
        req_valid = 4'b0010;
        req_data  = 32'h0000_3C00;
        out_ready = 1'b0;
        #1 check("stall.grant", {28'd0, req_ready}, 32'h2);
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d.ready", k), {28'd0, req_ready}, 32'h0);
            check_out($sformatf("stall%0d", k), 1'b1, 12'h3CA, 2'd1);
            req_data = 32'h0000_4400 + 32'(k);   // must not leak into the held word
            step();
        end
        req_valid = 4'b0000;
        out_ready = 1'b1;
        step();
        check_out("stall.drain", 1'b0, 12'h3CA, 2'd1);

        // enable=0: no grants for 10 cycles, the held word still drains.
        req_valid = 4'b0100;
        req_data  = 32'h0077_0000;
        out_ready = 1'b0;
        step();
        check_out("en.fill", 1'b1, 12'h77A, 2'd2);
        enable    = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            out_ready = (k >= 3);
            #1 check($sformatf("en%0d.ready", k), {28'd0, req_ready}, 32'h0);
            step();
            check($sformatf("en%0d.valid", k), {31'd0, out_valid}, {31'd0, (k < 3)});
        end
        check("en.code", {20'd0, out_codeword}, 32'h77A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_enc_share_arbiter

// File: doc/enc_share_arbiter.md
ENC_SHARE_ARBITER -- requirements
Module: enc_share_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one encoder (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data bits per request.
REQ-003 SHALL have parameter CODE_WIDTH, default 12, codeword bits (DATA_WIDTH + 4).
REQ-004 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  1 = arbitration allowed; 0 = no new grants.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester valid.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_ready  output  NUM_REQ  one-hot accept, asserted only in the cycle of grant.
REQ-010 SHALL have port out_valid  output  1  codeword valid.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_codeword  output  CODE_WIDTH  encoded word.
REQ-013 SHALL have port out_id  output  $clog2(NUM_REQ)  index of requester owning out_codeword.
REQ-014 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-015 Encoding SHALL be codeword = {data, 4'b1010}, data in [CODE_WIDTH-1:4], pattern 1010 in [3:0].
REQ-016 FSM SHALL have states IDLE and HOLD.
REQ-017 Grant SHALL occur in a cycle where enable=1, any req_valid=1, and (state=IDLE or (state=HOLD and out_ready=1)).
REQ-018 Grant winner SHALL be the first valid requester searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-019 On grant SHALL: req_ready[winner]=1 combinationally that cycle; register codeword and id; rr_ptr <= winner+1 mod NUM_REQ; state <= HOLD.
REQ-020 Latency SHALL be 1 cycle: data granted in cycle t appears with out_valid=1 in cycle t+1.
REQ-021 In HOLD with out_ready=0, out_codeword/out_id SHALL be stable and req_ready SHALL be all 0.
REQ-022 In HOLD with out_ready=1 and no grant possible, state SHALL go IDLE, out_valid=0 next cycle.
REQ-023 Simultaneous out_ready=1 and new grant in HOLD SHALL replace the output back-to-back (throughput 1 word/cycle).
REQ-024 enable=0 SHALL block new grants only; a word in HOLD SHALL still drain on out_ready.
REQ-025 rr_ptr SHALL not change in cycles without a grant.
REQ-026 req_valid dropping without req_ready SHALL be legal; no data captured.
REQ-027 out_valid SHALL equal (state==HOLD); busy SHALL equal out_valid.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, rr_ptr=0, out_codeword=0, out_id=0, out_valid=0, busy=0, req_ready=0.
REQ-029 Reset mid-HOLD SHALL discard the held word; no partial transfer after release.
REQ-030 First grant after reset release SHALL be no earlier than the first rising edge with rst_n=1.

Structure
REQ-031 Package cc_pkg SHALL hold DATA_WIDTH/CODE_WIDTH defaults, PAD_PATTERN=4'b1010, and the state enum {IDLE, HOLD}.
REQ-032 Encoding SHALL be a combinational sub-module direct_encoder (data in, codeword out) instantiated once, fed by the winner's data mux.
REQ-033 Round-robin pick SHALL be a function or combinational always block, not a further sub-module.

Verification
REQ-034 Reset then requester 2 sends 8'hAA, out_ready=1 -> next cycle out_codeword=12'hAAA, out_id=2, out_valid=1.
REQ-035 All 4 valid continuously, out_ready=1, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-036 Requester 1 sends 8'h3C, out_ready=0 for 5 cycles -> out_codeword holds 12'h3CA, req_ready all 0, then drains on out_ready=1.
REQ-037 enable=0 with req_valid=4'b1111 -> no req_ready for 10 cycles; held word still drains.
REQ-038 rst_n low mid-HOLD holding 12'hFFA -> out_valid=0, out_codeword=0 immediately; rr_ptr=0 after release.
REQ-039 Only requester 3 valid with rr_ptr=3, then only requester 0 -> grant 3 then 0 (wrap-around).
